// File: rtl/nzr_word_rx_pkg.sv
// Shared types and default timing for the WS2812B-style NZR word receiver.
// Holds the FSM state encoding, the bit classification and the GRB word geometry.
package nzr_pkg;

    localparam int GRB_W            = 24;
    localparam int T_SPLIT_DEF      = 64;
    localparam int T_MIN_DEF        = 16;
    localparam int T_MAX_DEF        = 120;
    localparam int RESET_CYCLES_DEF = 28000;

    localparam int HI_W  = 8;
    localparam int LO_W  = 15;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HIGH  = 2'd1,
        ST_LOW   = 2'd2,
        ST_STUCK = 2'd3
    } rx_state_e;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        ONE  = 2'd1,
        BAD  = 2'd2
    } bit_class_e;

endpackage

// File: rtl/nzr_word_rx_if.sv
// Line-side and word-side signals of the NZR receiver bundled as one interface.
// The slave modport is the receiver; the master modport drives the line and observes results.
interface nzr_word_rx_if;

    logic                        din;
    logic [nzr_pkg::GRB_W-1:0]   word;
    logic                        wvalid;
    logic                        rst_det;
    logic                        err;
    logic [nzr_pkg::CNT_W-1:0]   bit_cnt;

    modport master (
        output din,
        input  word,
        input  wvalid,
        input  rst_det,
        input  err,
        input  bit_cnt
    );

    modport slave (
        input  din,
        output word,
        output wvalid,
        output rst_det,
        output err,
        output bit_cnt
    );

endinterface

// File: rtl/nzr_word_rx_width_class.sv
// Combinational classifier: turns a measured high width into a ZERO, ONE or BAD bit.
// Widths below T_MIN or above T_MAX are framing errors.
module nzr_width_class
    import nzr_pkg::*;
#(
    parameter int T_SPLIT = T_SPLIT_DEF,
    parameter int T_MIN   = T_MIN_DEF,
    parameter int T_MAX   = T_MAX_DEF
) (
    input  logic [HI_W-1:0] w_i,
    output bit_class_e      cls_o
);

    int wInt;

    always_comb begin
        wInt  = int'(w_i);
        cls_o = BAD;
        if (wInt >= T_MIN && wInt < T_SPLIT) begin
            cls_o = ZERO;
        end else if (wInt >= T_SPLIT && wInt <= T_MAX) begin
            cls_o = ONE;
        end
    end

endmodule

// File: rtl/nzr_word_rx.sv
// NZR (WS2812B GRB) line receiver: synchronizes din, measures high/low widths,
// assembles 24-bit words and flags line RESETs and framing errors.
module nzr_word_rx
    import nzr_pkg::*;
#(
    parameter int T_SPLIT      = T_SPLIT_DEF,
    parameter int T_MIN        = T_MIN_DEF,
    parameter int T_MAX        = T_MAX_DEF,
    parameter int RESET_CYCLES = RESET_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    nzr_word_rx_if.slave      bus
);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] HIGH  = ST_HIGH;
    localparam logic [1:0] LOW   = ST_LOW;
    localparam logic [1:0] STUCK = ST_STUCK;

    localparam logic [HI_W-1:0]  HI_MAX   = '1;
    localparam logic [LO_W-1:0]  LO_MAX   = '1;
    localparam logic [LO_W-1:0]  LO_RESET = LO_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(GRB_W - 1);

    logic              sync1_q, sync2_q, dly_q;
    logic              rise_q, fall_q;
    logic [1:0]        state_q, state_d;
    logic [HI_W-1:0]   hi_q, hi_d;
    logic [LO_W-1:0]   lo_q, lo_d;
    logic [GRB_W-1:0]  shift_q, shift_d;
    logic [GRB_W-1:0]  word_q, word_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              wvalid_q, wvalid_d;
    logic              rst_det_q, rst_det_d;
    logic              err_q, err_d;
    bit_class_e        cls;

    nzr_width_class #(
        .T_SPLIT (T_SPLIT),
        .T_MIN   (T_MIN),
        .T_MAX   (T_MAX)
    ) u_width_class (
        .w_i   (hi_q),
        .cls_o (cls)
    );

    // Edge strobes are registered so the FSM sees them one cycle after the delay stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= bus.din;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
            rise_q  <= sync2_q & ~dly_q;
            fall_q  <= ~sync2_q & dly_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        shift_d   = shift_q;
        word_d    = word_q;
        bit_cnt_d = bit_cnt_q;
        wvalid_d  = 1'b0;
        rst_det_d = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise_q) begin
                    state_d = HIGH;
                    hi_d    = HI_W'(1);
                    lo_d    = '0;
                end
            end

            HIGH: begin
                if (fall_q) begin
                    state_d = LOW;
                    lo_d    = '0;
                    if (cls == BAD) begin
                        err_d     = 1'b1;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                    end else if (bit_cnt_q == LAST_BIT) begin
                        word_d    = {shift_q[GRB_W-2:0], cls == ONE};
                        wvalid_d  = 1'b1;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                    end else begin
                        shift_d   = {shift_q[GRB_W-2:0], cls == ONE};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (hi_q == HI_MAX - HI_W'(1)) begin
                    // Line stuck high: report once and park until it finally drops.
                    hi_d      = HI_MAX;
                    state_d   = STUCK;
                    err_d     = 1'b1;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end else begin
                    hi_d = hi_q + HI_W'(1);
                end
            end

            STUCK: begin
                if (fall_q) begin
                    state_d = LOW;
                    lo_d    = '0;
                end
            end

            LOW: begin
                if (rise_q) begin
                    state_d = HIGH;
                    hi_d    = HI_W'(1);
                    lo_d    = '0;
                end else if (lo_q == LO_RESET) begin
                    state_d   = IDLE;
                    rst_det_d = 1'b1;
                    shift_d   = '0;
                    if (bit_cnt_q != '0) begin
                        err_d     = 1'b1;
                        bit_cnt_d = '0;
                    end
                end else if (lo_q != LO_MAX) begin
                    lo_d = lo_q + LO_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            shift_q   <= '0;
            word_q    <= '0;
            bit_cnt_q <= '0;
            wvalid_q  <= 1'b0;
            rst_det_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            shift_q   <= shift_d;
            word_q    <= word_d;
            bit_cnt_q <= bit_cnt_d;
            wvalid_q  <= wvalid_d;
            rst_det_q <= rst_det_d;
            err_q     <= err_d;
        end
    end

    assign bus.word    = word_q;
    assign bus.wvalid  = wvalid_q;
    assign bus.rst_det = rst_det_q;
    assign bus.err     = err_q;
    assign bus.bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_nzr_word_rx.sv
// Self-checking bench for nzr_word_rx: width table plus hand-written word,
// RESET, stuck-high and mid-word reset sequences.
module tb_nzr_word_rx;
    import nzr_pkg::*;

    typedef struct {
        int   hi;
        int   expErr;
        int   expCnt;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    int nChecks = 0;
    int nErrors = 0;
    int wvCount = 0;
    int errCount = 0;
    int rstCount = 0;
    int pulseViol = 0;
    logic [23:0] lastWord = '0;
    logic rstWithErr = 1'b0;
    logic prevWv = 1'b0, prevErr = 1'b0, prevRst = 1'b0;

    vec_t vecs[10];

    nzr_word_rx_if bus();

    nzr_word_rx dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Pulse scoreboard sampled on the falling edge, away from register updates.
    always @(negedge clk) begin
        if (bus.wvalid) begin
            wvCount  <= wvCount + 1;
            lastWord <= bus.word;
        end
        if (bus.err) errCount <= errCount + 1;
        if (bus.rst_det) begin
            rstCount   <= rstCount + 1;
            rstWithErr <= bus.err;
        end
        if ((bus.wvalid && prevWv) || (bus.err && prevErr) || (bus.rst_det && prevRst))
            pulseViol <= pulseViol + 1;
        prevWv  <= bus.wvalid;
        prevErr <= bus.err;
        prevRst <= bus.rst_det;
    end

    initial begin
        repeat (150000) @(posedge clk);
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Starts at posedge+1 and returns at posedge+1 after hi+lo cycles.
    task automatic applyStimulus(input int hi, input int lo);
        bus.din = 1'b1;
        repeat (hi) @(posedge clk);
        #1 bus.din = 1'b0;
        repeat (lo) @(posedge clk);
        #1;
    endtask

    task automatic sendBits(input logic [23:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            if (val[i]) applyStimulus(92, 36);
            else        applyStimulus(36, 92);
        end
    endtask

    initial begin
        int wv0, e0, r0, k;
        logic [23:0] pat;

        vecs[0] = '{15,  1, 0};
        vecs[1] = '{16,  0, 1};
        vecs[2] = '{63,  0, 2};
        vecs[3] = '{64,  0, 3};
        vecs[4] = '{120, 0, 4};
        vecs[5] = '{121, 1, 0};
        vecs[6] = '{64,  0, 1};
        vecs[7] = '{16,  0, 2};
        vecs[8] = '{120, 0, 3};
        vecs[9] = '{63,  0, 4};

        reset   = 1'b0;
        bus.din = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("reset_word", bus.word, 0);
        checkOutput("reset_bit_cnt", bus.bit_cnt, 0);
        checkOutput("reset_wvalid", bus.wvalid, 0);
        checkOutput("reset_err", bus.err, 0);
        checkOutput("reset_rst_det", bus.rst_det, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Full word 0xA5C3F0 with exact output latency on the last bit.
        wv0 = wvCount; e0 = errCount; r0 = rstCount;
        pat = 24'hA5C3F0;
        for (int i = 23; i >= 1; i--) begin
            if (pat[i]) applyStimulus(92, 36);
            else        applyStimulus(36, 92);
        end
        checkOutput("bit_cnt_23", bus.bit_cnt, 23);
        bus.din = 1'b1;
        repeat (36) @(posedge clk);
        #1 bus.din = 1'b0;
        repeat (3) @(posedge clk);
        #1 checkOutput("latency_3cyc_wvalid", bus.wvalid, 0);
        @(posedge clk);
        #1 checkOutput("latency_4cyc_wvalid", bus.wvalid, 1);
        checkOutput("word_A5C3F0", bus.word, 24'hA5C3F0);
        checkOutput("bit_cnt_wrap", bus.bit_cnt, 0);
        repeat (30000) @(posedge clk);
        #1;
        checkOutput("wvalid_once", wvCount - wv0, 1);
        checkOutput("rst_det_once", rstCount - r0, 1);
        checkOutput("no_err_word", errCount - e0, 0);
        checkOutput("word_hold", bus.word, 24'hA5C3F0);

        // Width classification boundaries.
        for (int v = 0; v < 10; v++) begin
            e0 = errCount;
            applyStimulus(vecs[v].hi, 80);
            checkOutput($sformatf("err_w%0d", vecs[v].hi), errCount - e0, vecs[v].expErr);
            checkOutput($sformatf("bit_cnt_w%0d", vecs[v].hi), bus.bit_cnt, vecs[v].expCnt);
        end
        wv0 = wvCount;
        sendBits(24'h05A3C1, 20);
        checkOutput("wvalid_width_word", wvCount - wv0, 1);
        checkOutput("word_A5A3C1", lastWord, 24'hA5A3C1);

        // Partial word then line RESET: rst_det and err together.
        wv0 = wvCount; e0 = errCount; r0 = rstCount;
        sendBits(24'h0002B5 >> 1, 9);
        bus.din = 1'b1;
        repeat (92) @(posedge clk);
        #1 bus.din = 1'b0;
        repeat (27990) @(posedge clk);
        #1;
        checkOutput("rst_det_early", rstCount - r0, 0);
        checkOutput("bit_cnt_10", bus.bit_cnt, 10);
        k = 0;
        while (rstCount == r0 && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        checkOutput("rst_det_partial", rstCount - r0, 1);
        checkOutput("rst_with_err", rstWithErr, 1);
        checkOutput("err_partial", errCount - e0, 1);
        checkOutput("bit_cnt_after_rst", bus.bit_cnt, 0);
        checkOutput("no_wvalid_partial", wvCount - wv0, 0);

        // Stuck-high line.
        wv0 = wvCount; e0 = errCount;
        bus.din = 1'b1;
        repeat (200) @(posedge clk);
        #1 checkOutput("stuck_no_err_yet", errCount - e0, 0);
        repeat (200) @(posedge clk);
        #1 checkOutput("stuck_err_once", errCount - e0, 1);
        checkOutput("stuck_bit_cnt", bus.bit_cnt, 0);
        bus.din = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        checkOutput("stuck_fall_no_err", errCount - e0, 1);
        checkOutput("stuck_fall_no_bit", bus.bit_cnt, 0);
        sendBits(24'h3C5A96, 24);
        checkOutput("stuck_recover_wvalid", wvCount - wv0, 1);
        checkOutput("word_3C5A96", lastWord, 24'h3C5A96);
        checkOutput("stuck_recover_err", errCount - e0, 1);

        // Reset mid-word, then a clean word.
        e0 = errCount;
        sendBits(24'h000C3A, 12);
        checkOutput("bit_cnt_12", bus.bit_cnt, 12);
        reset = 1'b0;
        #2;
        checkOutput("midreset_bit_cnt", bus.bit_cnt, 0);
        checkOutput("midreset_word", bus.word, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        wv0 = wvCount;
        sendBits(24'h00FF00, 24);
        checkOutput("midreset_wvalid", wvCount - wv0, 1);
        checkOutput("word_00FF00", lastWord, 24'h00FF00);
        checkOutput("midreset_no_err", errCount - e0, 0);

        checkOutput("single_cycle_pulses", pulseViol, 0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/nzr_word_rx.md
NZR_WORD_RX -- requirements
Module: nzr_word_rx

Interface
REQ-001 Parameter T_SPLIT, default 64: high-width threshold in clk cycles; width < T_SPLIT decodes "0", width >= T_SPLIT decodes "1".
REQ-002 Parameter T_MIN, default 16: shortest legal high width in cycles.
REQ-003 Parameter T_MAX, default 120: longest legal high width in cycles.
REQ-004 Parameter RESET_CYCLES, default 28000: low time, in cycles, that constitutes a line RESET (280 us at 100 MHz).
REQ-005 clk  input  1  one clock, 100 MHz.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 din  input  1  asynchronous NZR line input (WS2812B GRB format).
REQ-008 word  output  24  last complete GRB word, G[7] received first, so word[23] is the first bit.
REQ-009 wvalid  output  1  one-cycle pulse when word is updated.
REQ-010 rst_det  output  1  one-cycle pulse when a line RESET is detected.
REQ-011 err  output  1  one-cycle pulse on any framing or width error.
REQ-012 bit_cnt  output  5  bits received in the current word, 0-23.

Function
REQ-013 din passes through a 2-FF synchronizer, then a 1-FF delay; a rising or falling edge is detected from the synchronized value and the delayed value.
REQ-014 FSM states: IDLE (wait for a rising edge), HIGH (count high cycles), LOW (count low cycles), STUCK (wait for a falling edge after overflow).
REQ-015 IDLE to HIGH, or LOW to HIGH, on a rising edge: the high counter loads 1; the low counter clears.
REQ-016 In HIGH, the 8-bit high counter increments each cycle and saturates at 255.
REQ-017 HIGH to LOW on a falling edge: the measured width w is classified in that same cycle.
REQ-018 Classification: if T_MIN <= w < T_SPLIT, shift in 0. If T_SPLIT <= w <= T_MAX, shift in 1. Otherwise, pulse err, clear bit_cnt, and discard the partial word.
REQ-019 The shift register shifts left and inserts the new bit at bit 0. bit_cnt increments on each valid bit.
REQ-020 On the 24th valid bit: load word with the completed value, pulse wvalid, and set bit_cnt to 0, all in the same clock edge.
REQ-021 Latency: wvalid rises exactly 4 clk cycles after the 24th falling edge on din (2 synchronizer + 1 edge + 1 output register).
REQ-022 HIGH to STUCK when the high counter reaches 255: pulse err once, clear bit_cnt. STUCK to LOW on a falling edge, with no bit decoded.
REQ-023 In LOW, the 15-bit low counter increments and saturates at 32767.
REQ-024 When the low counter equals RESET_CYCLES: pulse rst_det once, enter IDLE, clear the shift register. If bit_cnt != 0 at that moment, also pulse err in the same cycle and clear bit_cnt.
REQ-025 A rising edge in LOW before RESET_CYCLES is reached continues the current word; gaps between bits are not checked against a bit period.
REQ-026 word holds its value between wvalid pulses.
REQ-027 wvalid, rst_det and err are never asserted for more than one consecutive cycle per event.

Reset
REQ-028 On reset low, asynchronously: FSM to IDLE; all counters, shift register, word, bit_cnt, wvalid, rst_det, err and synchronizer flops to 0.
REQ-029 Reset asserted mid-word discards the word. After release, decoding resumes only at the next rising edge, with no err.

Structure
REQ-030 Shared package nzr_pkg holds the FSM state enum, the bit-class enum (ZERO, ONE, BAD), the default timing constants, and the GRB word width of 24.
REQ-031 One sub-module, nzr_width_class: purely combinational, maps w to ZERO, ONE or BAD using the parameters. All sequential logic stays in nzr_word_rx.

Verification
REQ-032 Reset, then 24 bits of 0xA5C3F0 (high 36 or 92 cycles, period 128), then 30000 low -> wvalid once with word=0xA5C3F0, then rst_det, err never.
REQ-033 High widths 15, 16, 63, 64, 120, 121 cycles -> err, 0, 0, 1, 1, err respectively. bit_cnt clears on each err.
REQ-034 10 valid bits, then 28000 cycles low -> rst_det and err in the same cycle, bit_cnt=0, no wvalid.
REQ-035 din held high 400 cycles -> single err pulse when the count reaches 255. The falling edge yields no bit. The next 24 valid bits produce a correct word.
REQ-036 Assert reset after bit 12 of a word, release, then send 24 bits 0x00FF00 -> wvalid with word=0x00FF00, no err.
